// File: rtl/ball_link_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ball_link_pkg
// Description : Shared types for the player-to-player ball link. Holds the
//               decoded ball frame, the default legal-y bound and the state
//               encoding of the receive-side frame unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package ball_link_pkg;

    // Ball y is legal only strictly below this screen line.
    localparam int Y_MAX_DEFAULT = 480;

    // Decoded ball state as handed to the local game logic.
    typedef struct packed {
        logic [9:0] y;
        logic [7:0] vy;         // two's complement
        logic [1:0] gravity;
        logic       collusion;
        logic       win;
    } ball_frame_t;

    // Receive FSM encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_PRESENT = 2'd2
    } rx_state_t;

endpackage : ball_link_pkg
`default_nettype wire

// File: rtl/ball_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : ball_frame_check
// Description : Purely combinational decode and validation of the six raw
//               register-bank bytes into a ball_frame_t.
// Ports       : y_pos0_i/y_pos1_i  - ball y low byte / high bits
//               y_vel_i            - signed vertical velocity
//               gravity_i          - gravity phase byte
//               collusion_i/win_i  - boolean bytes (0x00/0x01 only)
//               frame_o            - decoded frame
//               ok_o               - 1 when every field is in its legal range
// Revision    : 1.0 - initial release
// ============================================================================
module ball_frame_check
    import ball_link_pkg::*;
#(
    parameter int Y_MAX = Y_MAX_DEFAULT
) (
    input  logic [7:0]  y_pos0_i,
    input  logic [7:0]  y_pos1_i,
    input  logic [7:0]  y_vel_i,
    input  logic [7:0]  gravity_i,
    input  logic [7:0]  collusion_i,
    input  logic [7:0]  win_i,
    output ball_frame_t frame_o,
    output logic        ok_o
);

    logic [9:0] y_w;
    logic       y_ok_w;
    logic       pad_ok_w;
    logic       flag_ok_w;

    assign y_w = {y_pos1_i[1:0], y_pos0_i};

    // Zero-extend to 32 bits so the bound compare is done at full width.
    assign y_ok_w    = ({22'd0, y_w} < 32'(Y_MAX));
    // Unused upper bits of the packed bytes must be zero.
    assign pad_ok_w  = (y_pos1_i[7:2] == 6'd0) && (gravity_i[7:2] == 6'd0);
    // Flags are full bytes carrying a boolean: only 0x00 and 0x01 are legal.
    assign flag_ok_w = (collusion_i[7:1] == 7'd0) && (win_i[7:1] == 7'd0);

    assign ok_o = y_ok_w && pad_ok_w && flag_ok_w;

    always_comb begin
        frame_o           = '0;
        frame_o.y         = y_w;
        frame_o.vy        = y_vel_i;
        frame_o.gravity   = gravity_i[1:0];
        frame_o.collusion = collusion_i[0];
        frame_o.win       = win_i[0];
    end

endmodule : ball_frame_check
`default_nettype wire

// File: rtl/ball_rx_frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : ball_rx_frame_unpacker
// Description : Snapshots the six bytes of each completed I2C slave write,
//               validates them, and presents the decoded ball state over a
//               valid/ready handshake. Counts rejected and overrun frames and
//               runs a link watchdog while a ball is expected.
// Ports       : clk, reset (async, active-low)
//               is_slave_done           - write-burst done (pulse or level)
//               i_y_pos0 .. i_is_win_flag - raw register-bank bytes
//               expect_ball             - local game waits for a ball
//               rx_ready / rx_valid     - frame handshake
//               rx_ball_y, rx_ball_vy, rx_gravity, rx_collusion, rx_win
//               frame_err / overrun     - 1-cycle event pulses
//               err_cnt / ovr_cnt       - saturating event counters
//               link_timeout            - watchdog expired
// Revision    : 1.0 - initial release
// ============================================================================
module ball_rx_frame_unpacker
    import ball_link_pkg::*;
#(
    parameter int Y_MAX       = Y_MAX_DEFAULT,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_slave_done,
    input  logic [7:0]       i_y_pos0,
    input  logic [7:0]       i_y_pos1,
    input  logic [7:0]       i_y_vel,
    input  logic [7:0]       i_gravity,
    input  logic [7:0]       i_is_collusion,
    input  logic [7:0]       i_is_win_flag,
    input  logic             expect_ball,
    input  logic             rx_ready,
    output logic             rx_valid,
    output logic [9:0]       rx_ball_y,
    output logic [7:0]       rx_ball_vy,
    output logic [1:0]       rx_gravity,
    output logic             rx_collusion,
    output logic             rx_win,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic             link_timeout
);

    localparam int                WD_W   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    rx_state_t        state_q,   state_d;
    logic             done_q;
    logic [7:0]       pos0_q, pos1_q, vel_q, grav_q, col_q, win_q;
    ball_frame_t      rx_frame_q;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] ovr_cnt_q,   ovr_cnt_d;
    logic [WD_W-1:0]  wd_q,        wd_d;

    logic             new_frame;
    logic             load_rx;
    ball_frame_t      chk_frame;
    logic             chk_ok;

    // Only the rising edge of the done indication starts a frame, so a
    // level held high produces a single frame.
    assign new_frame = is_slave_done & ~done_q;

    // ------------------------------------------------------------------
    // Validation of the captured snapshot
    // ------------------------------------------------------------------
    ball_frame_check #(
        .Y_MAX (Y_MAX)
    ) u_check (
        .y_pos0_i    (pos0_q),
        .y_pos1_i    (pos1_q),
        .y_vel_i     (vel_q),
        .gravity_i   (grav_q),
        .collusion_i (col_q),
        .win_i       (win_q),
        .frame_o     (chk_frame),
        .ok_o        (chk_ok)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        load_rx     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_frame) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // A newer frame replaces the one under test without any
                // event; the check simply reruns on the fresh snapshot.
                if (new_frame) begin
                    state_d = S_CHECK;
                end else if (chk_ok) begin
                    state_d = S_PRESENT;
                    load_rx = 1'b1;
                end else begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            S_PRESENT: begin
                // A frame arriving together with rx_ready is a clean
                // hand-off; without rx_ready the held frame is lost.
                if (new_frame) begin
                    state_d   = S_CHECK;
                    overrun_d = ~rx_ready;
                end else if (rx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_d && (ovr_cnt_q != CNT_MAX)) begin
            ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
    end

    // Watchdog runs only while a ball is expected; a frame that passes the
    // check restarts it. It parks at WD_MAX so the timeout stays asserted.
    always_comb begin
        wd_d = wd_q;
        if (!expect_ball || load_rx) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            pos0_q      <= '0;
            pos1_q      <= '0;
            vel_q       <= '0;
            grav_q      <= '0;
            col_q       <= '0;
            win_q       <= '0;
            rx_frame_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_cnt_q   <= '0;
            ovr_cnt_q   <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= is_slave_done;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            err_cnt_q   <= err_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
            wd_q        <= wd_d;
            if (new_frame) begin
                pos0_q <= i_y_pos0;
                pos1_q <= i_y_pos1;
                vel_q  <= i_y_vel;
                grav_q <= i_gravity;
                col_q  <= i_is_collusion;
                win_q  <= i_is_win_flag;
            end
            if (load_rx) begin
                rx_frame_q <= chk_frame;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_valid     = (state_q == S_PRESENT);
    assign rx_ball_y    = rx_frame_q.y;
    assign rx_ball_vy   = rx_frame_q.vy;
    assign rx_gravity   = rx_frame_q.gravity;
    assign rx_collusion = rx_frame_q.collusion;
    assign rx_win       = rx_frame_q.win;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign err_cnt      = err_cnt_q;
    assign ovr_cnt      = ovr_cnt_q;
    assign link_timeout = (wd_q == WD_MAX);

endmodule : ball_rx_frame_unpacker
`default_nettype wire

// File: tb/tb_ball_rx_frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_rx_frame_unpacker
// Description : Directed self-checking bench for ball_rx_frame_unpacker.
//               Inputs change and outputs are sampled 1 ns after each rising
//               clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_rx_frame_unpacker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       is_slave_done = 1'b0;
    logic [7:0] i_y_pos0 = '0, i_y_pos1 = '0, i_y_vel = '0;
    logic [7:0] i_gravity = '0, i_is_collusion = '0, i_is_win_flag = '0;
    logic       expect_ball = 1'b0;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [9:0] rx_ball_y;
    logic [7:0] rx_ball_vy;
    logic [1:0] rx_gravity;
    logic       rx_collusion, rx_win, frame_err, overrun, link_timeout;
    logic [7:0] err_cnt, ovr_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ball_rx_frame_unpacker #(
        .Y_MAX       (480),
        .TIMEOUT_CYC (100),
        .CNT_W       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_slave_done  (is_slave_done),
        .i_y_pos0       (i_y_pos0),
        .i_y_pos1       (i_y_pos1),
        .i_y_vel        (i_y_vel),
        .i_gravity      (i_gravity),
        .i_is_collusion (i_is_collusion),
        .i_is_win_flag  (i_is_win_flag),
        .expect_ball    (expect_ball),
        .rx_ready       (rx_ready),
        .rx_valid       (rx_valid),
        .rx_ball_y      (rx_ball_y),
        .rx_ball_vy     (rx_ball_vy),
        .rx_gravity     (rx_gravity),
        .rx_collusion   (rx_collusion),
        .rx_win         (rx_win),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .err_cnt        (err_cnt),
        .ovr_cnt        (ovr_cnt),
        .link_timeout   (link_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bytes(input logic [7:0] p0, p1, v, g, c, w);
        i_y_pos0 = p0; i_y_pos1 = p1; i_y_vel = v;
        i_gravity = g; i_is_collusion = c; i_is_win_flag = w;
    endtask

    // Edge in the current cycle N; returns sampled in cycle N+1.
    task automatic send(input logic [7:0] p0, p1, v, g, c, w);
        set_bytes(p0, p1, v, g, c, w);
        is_slave_done = 1'b1;
        tick();
        is_slave_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rx_valid); else n_pass++;
        n_total++; if (err_cnt !== 8'h00 || ovr_cnt !== 8'h00) $display("FAIL rst_cnt: got err=%h ovr=%h want 00/00", err_cnt, ovr_cnt); else n_pass++;
        n_total++; if ({frame_err, overrun, link_timeout} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {frame_err, overrun, link_timeout}); else n_pass++;
        n_total++; if (rx_ball_y !== 10'd0 || rx_ball_vy !== 8'd0) $display("FAIL rst_data: got y=%0d vy=%h want 0/00", rx_ball_y, rx_ball_vy); else n_pass++;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rx_ready = 1'b1;
        send(8'h2C, 8'h01, 8'hFB, 8'h02, 8'h00, 8'h00);
        n_total++; if (rx_valid !== 1'b0) $display("FAIL basic_n1_valid: got %b want 0", rx_valid); else n_pass++;
        tick();
        n_total++; if (rx_valid !== 1'b1) $display("FAIL basic_n2_valid: got %b want 1", rx_valid); else n_pass++;
        n_total++; if (rx_ball_y !== 10'd300 || rx_ball_vy !== 8'hFB || rx_gravity !== 2'd2)
            $display("FAIL basic_data: got y=%0d vy=%h g=%0d want 300/FB/2", rx_ball_y, rx_ball_vy, rx_gravity); else n_pass++;
        n_total++; if (rx_collusion !== 1'b0 || rx_win !== 1'b0) $display("FAIL basic_flags: got c=%b w=%b want 0/0", rx_collusion, rx_win); else n_pass++;
        tick();
        n_total++; if (rx_valid !== 1'b0) $display("FAIL basic_single_cycle: got %b want 0", rx_valid); else n_pass++;
        // Largest legal y with both flags set.
        send(8'hDF, 8'h01, 8'h7F, 8'h03, 8'h01, 8'h01);
        tick();
        n_total++; if (rx_valid !== 1'b1 || rx_ball_y !== 10'd479 || rx_ball_vy !== 8'h7F || rx_gravity !== 2'd3)
            $display("FAIL edge_y479: got v=%b y=%0d vy=%h g=%0d want 1/479/7F/3", rx_valid, rx_ball_y, rx_ball_vy, rx_gravity); else n_pass++;
        n_total++; if (rx_collusion !== 1'b1 || rx_win !== 1'b1 || frame_err !== 1'b0)
            $display("FAIL edge_flags: got c=%b w=%b err=%b want 1/1/0", rx_collusion, rx_win, frame_err); else n_pass++;
        tick();
    endtask

    task automatic test_bad_frames();
        int seen_valid;
        rx_ready = 1'b1;
        seen_valid = 0;
        send(8'hE0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);   // y = 480
        if (rx_valid) seen_valid++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL bad_n1_err: got %b want 0", frame_err); else n_pass++;
        tick();
        if (rx_valid) seen_valid++;
        n_total++; if (frame_err !== 1'b1 || err_cnt !== 8'd1) $display("FAIL bad_y480: got err=%b cnt=%0d want 1/1", frame_err, err_cnt); else n_pass++;
        tick();
        if (rx_valid) seen_valid++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL bad_pulse_width: got %b want 0", frame_err); else n_pass++;
        n_total++; if (seen_valid !== 0) $display("FAIL bad_no_valid: got %0d valid cycles want 0", seen_valid); else n_pass++;
        send(8'h2C, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00); tick();  // pos1 pad bit
        send(8'h2C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00); tick();  // gravity pad bit
        send(8'h2C, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00); tick();  // collision 0x02
        send(8'h2C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02); tick();  // win 0x02
        n_total++; if (err_cnt !== 8'd5 || rx_valid !== 1'b0) $display("FAIL bad_fields: got cnt=%0d v=%b want 5/0", err_cnt, rx_valid); else n_pass++;
        for (int i = 0; i < 249; i++) begin
            send(8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        end
        n_total++; if (err_cnt !== 8'hFE) $display("FAIL bad_cnt_254: got %h want FE", err_cnt); else n_pass++;
        send(8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        send(8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        n_total++; if (err_cnt !== 8'hFF || frame_err !== 1'b1) $display("FAIL bad_cnt_sat: got cnt=%h err=%b want FF/1", err_cnt, frame_err); else n_pass++;
        tick();
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send(8'h64, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00);   // A: y=100
        tick();
        n_total++; if (rx_valid !== 1'b1 || rx_ball_y !== 10'd100) $display("FAIL ovr_A: got v=%b y=%0d want 1/100", rx_valid, rx_ball_y); else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        send(8'hC8, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00);   // B: y=200
        n_total++; if (overrun !== 1'b1 || ovr_cnt !== 8'd1 || rx_valid !== 1'b0)
            $display("FAIL ovr_pulse: got o=%b cnt=%0d v=%b want 1/1/0", overrun, ovr_cnt, rx_valid); else n_pass++;
        tick();
        n_total++; if (rx_valid !== 1'b1 || rx_ball_y !== 10'd200 || rx_ball_vy !== 8'hF0 || overrun !== 1'b0)
            $display("FAIL ovr_B: got v=%b y=%0d vy=%h o=%b want 1/200/F0/0", rx_valid, rx_ball_y, rx_ball_vy, overrun); else n_pass++;
        rx_ready = 1'b1;
        tick();
        n_total++; if (rx_valid !== 1'b0) $display("FAIL ovr_consume: got %b want 0", rx_valid); else n_pass++;
        tick(); tick();
        n_total++; if (rx_valid !== 1'b0 || ovr_cnt !== 8'd1) $display("FAIL ovr_only_B: got v=%b cnt=%0d want 0/1", rx_valid, ovr_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int valid_cycles;
        rx_ready = 1'b1;
        valid_cycles = 0;
        set_bytes(8'h0A, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        is_slave_done = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rx_valid) valid_cycles++;
        end
        is_slave_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rx_valid) valid_cycles++;
        end
        n_total++; if (valid_cycles !== 1) $display("FAIL held_level: got %0d frames want 1", valid_cycles); else n_pass++;
        // Hold a frame, then land a new edge in the same cycle as rx_ready.
        rx_ready = 1'b0;
        send(8'h32, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00);   // C: y=50
        tick();
        rx_ready = 1'b1;
        send(8'h96, 8'h00, 8'h04, 8'h02, 8'h00, 8'h00);   // D: y=150
        rx_ready = 1'b0;
        n_total++; if (overrun !== 1'b0 || ovr_cnt !== 8'd1) $display("FAIL coincide_no_ovr: got o=%b cnt=%0d want 0/1", overrun, ovr_cnt); else n_pass++;
        tick();
        n_total++; if (rx_valid !== 1'b1 || rx_ball_y !== 10'd150 || rx_gravity !== 2'd2)
            $display("FAIL coincide_D: got v=%b y=%0d g=%0d want 1/150/2", rx_valid, rx_ball_y, rx_gravity); else n_pass++;
        rx_ready = 1'b1;
        tick();
    endtask

    task automatic test_watchdog();
        expect_ball = 1'b1;
        for (int i = 0; i < 99; i++) tick();
        n_total++; if (link_timeout !== 1'b0) $display("FAIL wd_99: got %b want 0", link_timeout); else n_pass++;
        tick();
        n_total++; if (link_timeout !== 1'b1) $display("FAIL wd_100: got %b want 1", link_timeout); else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_total++; if (link_timeout !== 1'b1) $display("FAIL wd_sat: got %b want 1", link_timeout); else n_pass++;
        rx_ready = 1'b1;
        send(8'h2C, 8'h01, 8'hFB, 8'h02, 8'h00, 8'h00);
        tick();
        n_total++; if (link_timeout !== 1'b0 || rx_valid !== 1'b1) $display("FAIL wd_frame_clear: got t=%b v=%b want 0/1", link_timeout, rx_valid); else n_pass++;
        for (int i = 0; i < 100; i++) tick();
        n_total++; if (link_timeout !== 1'b1) $display("FAIL wd_rearm: got %b want 1", link_timeout); else n_pass++;
        expect_ball = 1'b0;
        tick();
        n_total++; if (link_timeout !== 1'b0) $display("FAIL wd_expect_clear: got %b want 0", link_timeout); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b0;
        send(8'h64, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00);   // now in S_CHECK
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (rx_valid !== 1'b0 || err_cnt !== 8'h00 || ovr_cnt !== 8'h00 || rx_ball_y !== 10'd0)
            $display("FAIL midrst_clear: got v=%b err=%h ovr=%h y=%0d want 0/00/00/0", rx_valid, err_cnt, ovr_cnt, rx_ball_y); else n_pass++;
        tick(); tick();
        n_total++; if ({rx_valid, frame_err, overrun} !== 3'b000) $display("FAIL midrst_hold: got %b want 000", {rx_valid, frame_err, overrun}); else n_pass++;
        reset = 1'b1;
        tick();
        rx_ready = 1'b1;
        send(8'hC8, 8'h00, 8'hF0, 8'h03, 8'h00, 8'h01);
        tick();
        n_total++; if (rx_valid !== 1'b1 || rx_ball_y !== 10'd200 || rx_win !== 1'b1)
            $display("FAIL midrst_next: got v=%b y=%0d w=%b want 1/200/1", rx_valid, rx_ball_y, rx_win); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_frames();
        test_overrun();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ball_rx_frame_unpacker
`default_nettype wire
